// File: rtl/lab3_pkg.sv
// Shared types and constants for the lab3 response checker.
package lab3_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Golden truth tables for the default 3-input full adder.
  // Bit i is the expected output for vector i = {a,b,c}.
  localparam logic [7:0] EXP_X_DEF = 8'b1110_1000;  // majority / carry
  localparam logic [7:0] EXP_Y_DEF = 8'b1001_0110;  // parity / sum

  // Width needed to count 0..n mismatching vectors
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lab3_golden_cmp.sv
// Golden lookup: compares one observed (x, y) pair against the truth tables.
module lab3_golden_cmp
  import lab3_pkg::*;
#(
  parameter int                        NUM_IN = 3,
  parameter logic [(2**NUM_IN)-1:0]    EXP_X  = EXP_X_DEF,
  parameter logic [(2**NUM_IN)-1:0]    EXP_Y  = EXP_Y_DEF
) (
  input  logic [NUM_IN-1:0] vec_idx,
  input  logic              x_in,
  input  logic              y_in,
  output logic              mismatch
);

  // One flag per vector: a double-bit error still counts once
  always_comb begin
    mismatch = (x_in != EXP_X[vec_idx]) || (y_in != EXP_Y[vec_idx]);
  end

endmodule

// File: rtl/lab3_resp_checker.sv
// Response checker: walks the exhaustive vector sweep over a valid/ready
// handshake, counts mismatches and records the first failing vector.
module lab3_resp_checker
  import lab3_pkg::*;
#(
  parameter int                        NUM_IN = 3,
  parameter logic [(2**NUM_IN)-1:0]    EXP_X  = EXP_X_DEF,
  parameter logic [(2**NUM_IN)-1:0]    EXP_Y  = EXP_Y_DEF,
  localparam int                       N      = 2**NUM_IN,
  localparam int                       CW     = cnt_width(2**NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              x_in,
  input  logic              y_in,
  output logic [NUM_IN-1:0] vec_idx,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CW-1:0]     err_count,
  output logic              fail_valid,
  output logic [NUM_IN-1:0] first_fail_idx
);

  localparam logic [NUM_IN-1:0] LAST_IDX = NUM_IN'(N - 1);

  state_e            state_q, state_d;
  logic [NUM_IN-1:0] vec_idx_q, vec_idx_d;
  logic [CW-1:0]     err_count_q, err_count_d;
  logic              fail_valid_q, fail_valid_d;
  logic [NUM_IN-1:0] first_fail_q, first_fail_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              mismatch;
  logic              transfer;

  lab3_golden_cmp #(
    .NUM_IN (NUM_IN),
    .EXP_X  (EXP_X),
    .EXP_Y  (EXP_Y)
  ) u_golden_cmp (
    .vec_idx  (vec_idx_q),
    .x_in     (x_in),
    .y_in     (y_in),
    .mismatch (mismatch)
  );

  // Next-state, counters and first-fail record; status flags follow next state
  always_comb begin
    state_d      = state_q;
    vec_idx_d    = vec_idx_q;
    err_count_d  = err_count_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;
    transfer     = (state_q == RUN) && in_valid;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RUN;
          vec_idx_d    = '0;
          err_count_d  = '0;
          fail_valid_d = 1'b0;
          first_fail_d = '0;
        end
      end
      RUN: begin
        // start is deliberately ignored here so a sweep cannot be restarted
        if (transfer) begin
          if (mismatch) begin
            err_count_d = err_count_q + CW'(1);
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              first_fail_d = vec_idx_q;
            end
          end
          if (vec_idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            vec_idx_d = vec_idx_q + NUM_IN'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered from the next state so in_ready never sees in_valid combinationally
    in_ready_d = (state_d == RUN);
    busy_d     = (state_d == RUN);
    done_d     = (state_d == DONE);
    pass_d     = (state_d == DONE) && (err_count_d == '0);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_idx_q    <= '0;
      err_count_q  <= '0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_idx_q    <= vec_idx_d;
      err_count_q  <= err_count_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign vec_idx        = vec_idx_q;
  assign err_count      = err_count_q;
  assign fail_valid     = fail_valid_q;
  assign first_fail_idx = first_fail_q;

endmodule

// File: tb/tb_lab3_resp_checker.sv
// Randomized self-checking bench for lab3_resp_checker against a sweep-level model.
module tb_lab3_resp_checker;

  localparam int NUM_IN = 3;
  localparam int N      = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic       x_in;
  logic       y_in;
  logic [2:0] vec_idx;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic       fail_valid;
  logic [2:0] first_fail_idx;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model of one sweep, kept at the level of the written rules
  bit m_running;
  bit m_done;
  int m_pos;
  int m_err;
  bit m_fv;
  int m_first;

  always #5 clk = ~clk;

  lab3_resp_checker #(.NUM_IN(NUM_IN)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .x_in           (x_in),
    .y_in           (y_in),
    .vec_idx        (vec_idx),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .fail_valid     (fail_valid),
    .first_fail_idx (first_fail_idx)
  );

  // Full-adder truth: carry is majority of the three inputs, sum is their parity
  function automatic bit gold_x(input int i);
    int ones = ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1);
    return ones >= 2;
  endfunction

  function automatic bit gold_y(input int i);
    int ones = ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1);
    return (ones % 2) == 1;
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply the rules to whatever the bench drove at this edge
  task automatic model_edge();
    bit bad;
    if (rst) begin
      m_running = 0; m_done = 0; m_pos = 0; m_err = 0; m_fv = 0; m_first = 0;
    end else if (m_running) begin
      if (in_valid) begin
        bad = (x_in != gold_x(m_pos)) || (y_in != gold_y(m_pos));
        if (bad) begin
          m_err++;
          if (!m_fv) begin
            m_fv = 1;
            m_first = m_pos;
          end
        end
        if (m_pos == N - 1) begin
          m_running = 0;
          m_done = 1;
        end else begin
          m_pos++;
        end
      end
    end else if (start) begin
      m_running = 1; m_done = 0; m_pos = 0; m_err = 0; m_fv = 0; m_first = 0;
    end
  endtask

  // One clock: model follows the edge, outputs are checked 1 time unit later
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("in_ready", in_ready, m_running);
    check_eq("busy", busy, m_running);
    check_eq("done", done, m_done);
    check_eq("pass", pass, (m_done && m_err == 0));
    check_eq("vec_idx", vec_idx, m_pos);
    check_eq("err_count", err_count, m_err);
    check_eq("fail_valid", fail_valid, m_fv);
    check_eq("first_fail_idx", first_fail_idx, m_first);
    $display("[TB] t=%0t rst=%0b start=%0b v=%0b x=%0b y=%0b | idx=%0d err=%0d done=%0b pass=%0b",
             $time, rst, start, in_valid, x_in, y_in, vec_idx, err_count, done, pass);
  endtask

  // Drive one sweep; fx/fy flip the correct response at chosen indices
  task automatic run_sweep(input logic [7:0] fx, input logic [7:0] fy,
                           input int gap_pct, input bit mid_start, input int max_xfers);
    int xfers = 0;
    int cycles = 0;
    logic [7:0] fxv;
    logic [7:0] fyv;
    fxv = fx;
    fyv = fy;
    start = 1; in_valid = 0;
    cyc();
    start = 0;
    while (m_running && xfers < max_xfers && cycles < 200) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      x_in  = gold_x(m_pos) ^ fxv[m_pos];
      y_in  = gold_y(m_pos) ^ fyv[m_pos];
      start = mid_start && ($urandom_range(3) == 0);
      if (in_valid) xfers++;
      cyc();
      cycles++;
    end
    in_valid = 0; start = 0;
    if (max_xfers >= N) check_eq("sweep_completes", done, 1);
  endtask

  initial begin
    int t0;
    rst = 1; start = 0; in_valid = 0; x_in = 0; y_in = 0;
    m_running = 0; m_done = 0; m_pos = 0; m_err = 0; m_fv = 0; m_first = 0;
    cyc();
    cyc();
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_err", err_count, 0);
    rst = 0;

    // Clean back-to-back sweep: 8 transfers then verdict one cycle later
    t0 = tests_run;
    run_sweep(8'h00, 8'h00, 0, 0, N);
    check_eq("s1_pass", pass, 1);
    check_eq("s1_err", err_count, 0);
    check_eq("s1_fv", fail_valid, 0);

    // x wrong at 3, y wrong at 5
    run_sweep(8'b0000_1000, 8'b0010_0000, 0, 0, N);
    check_eq("s2_err", err_count, 2);
    check_eq("s2_first", first_fail_idx, 3);
    check_eq("s2_pass", pass, 0);

    // Both bits wrong at 6 counts once
    run_sweep(8'b0100_0000, 8'b0100_0000, 0, 0, N);
    check_eq("s3_err", err_count, 1);
    check_eq("s3_first", first_fail_idx, 6);

    // Stalls and ignored mid-sweep start
    run_sweep(8'h00, 8'h00, 50, 1, N);
    check_eq("s4_pass", pass, 1);

    // Reset after 4 transfers with one error
    run_sweep(8'b0000_0010, 8'h00, 0, 0, 4);
    check_eq("s5_fv_before_rst", fail_valid, 1);
    rst = 1;
    cyc();
    rst = 0;
    check_eq("s5_rst_idx", vec_idx, 0);
    check_eq("s5_rst_busy", busy, 0);
    run_sweep(8'h00, 8'h00, 0, 0, N);
    check_eq("s5_pass", pass, 1);

    // All wrong, then in_valid in DONE, then clean restart from DONE
    run_sweep(8'hFF, 8'h00, 0, 0, N);
    check_eq("s6_err", err_count, 8);
    check_eq("s6_first", first_fail_idx, 0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; x_in = ~x_in;
      cyc();
    end
    in_valid = 0;
    check_eq("s6_done_hold", err_count, 8);
    run_sweep(8'h00, 8'h00, 0, 0, N);
    check_eq("s6b_err", err_count, 0);
    check_eq("s6b_fv", fail_valid, 0);
    check_eq("s6b_pass", pass, 1);

    // Random soak: random start, stalls, data and rare resets
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(49) == 0);
      start    = ($urandom_range(9) == 0);
      in_valid = ($urandom_range(99) < 60);
      x_in     = ($urandom_range(3) == 0) ? ~gold_x(m_pos) : gold_x(m_pos);
      y_in     = ($urandom_range(3) == 0) ? ~gold_y(m_pos) : gold_y(m_pos);
      cyc();
    end
    rst = 0; start = 0; in_valid = 0;
    cyc();

    if (tests_run == t0) check_eq("no_checks", tests_run, t0 + 1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
